// File: rtl/scan_mux.sv
// scan_mux: registered N:1 channel selector with manual select and auto-scan
// modes, holding each captured sample under a valid/ready handshake.
module scan_mux #(
    parameter  int WIDTH    = 1,
    parameter  int CHANNELS = 8,
    localparam int SEL_W    = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS*WIDTH-1:0] d_in,
    input  logic [SEL_W-1:0]          sel,
    input  logic                      mode,
    input  logic                      en,
    input  logic                      out_ready,
    output logic [WIDTH-1:0]          y,
    output logic                      y_valid,
    output logic [SEL_W-1:0]          y_ch,
    output logic                      y_last,
    output logic                      sel_err
);

    localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(CHANNELS - 1);

    logic [WIDTH-1:0] y_q, y_d;
    logic             y_valid_q, y_valid_d;
    logic [SEL_W-1:0] y_ch_q, y_ch_d;
    logic             y_last_q, y_last_d;
    logic             sel_err_q, sel_err_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;

    logic             capture;
    logic             sel_ok;
    logic [SEL_W-1:0] idx;
    logic [WIDTH-1:0] mux_data;

    // Channel mux: scan pointer in auto mode, sel in manual mode; out-of-range
    // indices match no channel and yield zero.
    always_comb begin
        capture  = en && (!y_valid_q || out_ready);
        sel_ok   = ({1'b0, sel} < (SEL_W + 1)'(CHANNELS));
        idx      = mode ? ptr_q : sel;
        mux_data = '0;
        for (int unsigned k = 0; k < CHANNELS; k++) begin
            if (idx == SEL_W'(k)) begin
                mux_data = d_in[k*WIDTH +: WIDTH];
            end
        end
    end

    // Next-state for the held sample, handshake flag and scan pointer.
    always_comb begin
        y_d       = y_q;
        y_valid_d = y_valid_q;
        y_ch_d    = y_ch_q;
        y_last_d  = y_last_q;
        sel_err_d = sel_err_q;
        ptr_d     = ptr_q;

        if (capture) begin
            y_valid_d = 1'b1;
            y_d       = mux_data;
            y_ch_d    = idx;
            if (mode) begin
                y_last_d  = (ptr_q == LAST_CH);
                sel_err_d = 1'b0;
            end else begin
                y_last_d  = 1'b0;
                sel_err_d = !sel_ok;
            end
        end else if (out_ready) begin
            y_valid_d = 1'b0;
        end

        // Pointer parks at 0 in manual mode so a scan always starts at channel 0.
        if (!mode) begin
            ptr_d = '0;
        end else if (capture) begin
            ptr_d = (ptr_q == LAST_CH) ? '0 : ptr_q + 1'b1;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q       <= '0;
            y_valid_q <= 1'b0;
            y_ch_q    <= '0;
            y_last_q  <= 1'b0;
            sel_err_q <= 1'b0;
            ptr_q     <= '0;
        end else begin
            y_q       <= y_d;
            y_valid_q <= y_valid_d;
            y_ch_q    <= y_ch_d;
            y_last_q  <= y_last_d;
            sel_err_q <= sel_err_d;
            ptr_q     <= ptr_d;
        end
    end

    assign y       = y_q;
    assign y_valid = y_valid_q;
    assign y_ch    = y_ch_q;
    assign y_last  = y_last_q;
    assign sel_err = sel_err_q;

endmodule

// File: tb/tb_scan_mux.sv
// tb_scan_mux: two scan_mux instances (8x1-bit and 6x4-bit) checked every
// cycle against a sample-level reference model.
module tb_scan_mux;

    logic clk;
    logic rst_n;

    // Instance A: CHANNELS=8, WIDTH=1
    logic [7:0]  d8;
    logic [2:0]  sel8;
    logic        mode8, en8, rdy8;
    logic [0:0]  y8;
    logic        v8, last8, err8;
    logic [2:0]  ch8;

    // Instance B: CHANNELS=6, WIDTH=4
    logic [23:0] d6;
    logic [2:0]  sel6;
    logic        mode6, en6, rdy6;
    logic [3:0]  y6;
    logic        v6, last6, err6;
    logic [2:0]  ch6;

    int checks;
    int failures;

    // Reference model state, index 0 = instance A, 1 = instance B
    logic [3:0] m_y    [2];
    logic       m_valid[2];
    logic [2:0] m_ch   [2];
    logic       m_last [2];
    logic       m_err  [2];
    int         m_scan_n[2];

    scan_mux #(.WIDTH(1), .CHANNELS(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .d_in(d8), .sel(sel8), .mode(mode8),
        .en(en8), .out_ready(rdy8), .y(y8), .y_valid(v8), .y_ch(ch8),
        .y_last(last8), .sel_err(err8)
    );

    scan_mux #(.WIDTH(4), .CHANNELS(6)) dut_b (
        .clk(clk), .rst_n(rst_n), .d_in(d6), .sel(sel6), .mode(mode6),
        .en(en6), .out_ready(rdy6), .y(y6), .y_valid(v6), .y_ch(ch6),
        .y_last(last6), .sel_err(err6)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_y[i] = '0; m_valid[i] = 1'b0; m_ch[i] = '0;
            m_last[i] = 1'b0; m_err[i] = 1'b0; m_scan_n[i] = 0;
        end
    endtask

    // Sample-level behaviour: the n-th scan capture since leaving manual mode
    // (or reset) reads channel n mod C.
    task automatic model_step(input int id, input int c, input int w, input logic [23:0] d,
                              input int sel, input logic mode, input logic en, input logic rdy);
        int   pos;
        logic cap;
        logic [23:0] mask;
        mask = (24'd1 << w) - 24'd1;
        cap  = en && (!m_valid[id] || rdy);
        if (cap) begin
            m_valid[id] = 1'b1;
            if (mode) begin
                pos          = m_scan_n[id] % c;
                m_y[id]      = 4'((d >> (pos * w)) & mask);
                m_ch[id]     = 3'(pos);
                m_last[id]   = (pos == c - 1);
                m_err[id]    = 1'b0;
                m_scan_n[id] = m_scan_n[id] + 1;
            end else if (sel < c) begin
                m_y[id]    = 4'((d >> (sel * w)) & mask);
                m_ch[id]   = 3'(sel);
                m_last[id] = 1'b0;
                m_err[id]  = 1'b0;
            end else begin
                m_y[id]    = '0;
                m_ch[id]   = 3'(sel);
                m_last[id] = 1'b0;
                m_err[id]  = 1'b1;
            end
        end else if (rdy) begin
            m_valid[id] = 1'b0;
        end
        if (!mode) m_scan_n[id] = 0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".a.y"},     {7'd0, y8},    {4'd0, m_y[0]});
        chk({tag, ".a.valid"}, {7'd0, v8},    {7'd0, m_valid[0]});
        chk({tag, ".a.ch"},    {5'd0, ch8},   {5'd0, m_ch[0]});
        chk({tag, ".a.last"},  {7'd0, last8}, {7'd0, m_last[0]});
        chk({tag, ".a.err"},   {7'd0, err8},  {7'd0, m_err[0]});
        chk({tag, ".b.y"},     {4'd0, y6},    {4'd0, m_y[1]});
        chk({tag, ".b.valid"}, {7'd0, v6},    {7'd0, m_valid[1]});
        chk({tag, ".b.ch"},    {5'd0, ch6},   {5'd0, m_ch[1]});
        chk({tag, ".b.last"},  {7'd0, last6}, {7'd0, m_last[1]});
        chk({tag, ".b.err"},   {7'd0, err6},  {7'd0, m_err[1]});
    endtask

    // One clock: model sees inputs as they stood at the edge; outputs checked #1 later.
    task automatic cycle(input string tag);
        @(posedge clk);
        if (rst_n) begin
            model_step(0, 8, 1, {16'd0, d8}, int'(sel8), mode8, en8, rdy8);
            model_step(1, 6, 4, d6, int'(sel6), mode6, en6, rdy6);
        end
        #1;
        check_all(tag);
    endtask

    task automatic rand_a();
        d8 = 8'($urandom); sel8 = 3'($urandom);
        mode8 = 1'($urandom); en8 = ($urandom_range(0, 3) != 0);
        rdy8 = ($urandom_range(0, 2) != 0);
    endtask

    task automatic rand_b();
        d6 = 24'($urandom); sel6 = 3'($urandom);
        mode6 = ($urandom_range(0, 3) != 0); en6 = ($urandom_range(0, 3) != 0);
        rdy6 = ($urandom_range(0, 2) != 0);
    endtask

    initial begin
        checks = 0; failures = 0;
        model_reset();
        rst_n = 1'b0;
        d8 = '0; sel8 = '0; mode8 = 1'b0; en8 = 1'b0; rdy8 = 1'b0;
        d6 = '0; sel6 = '0; mode6 = 1'b0; en6 = 1'b0; rdy6 = 1'b0;

        // Reset state
        cycle("reset");
        cycle("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // A: exhaustive manual sweep of {sel,d_in}; B: random traffic
        for (int v = 0; v < 2048; v++) begin
            {sel8, d8} = 11'(v);
            mode8 = 1'b0; en8 = 1'b1; rdy8 = 1'b1;
            rand_b();
            cycle("sweep");
            chk("sweep.err_a", {7'd0, err8}, 8'd0);
        end

        // B: out-of-range manual select
        rand_a();
        d6 = 24'hFFFFFF; sel6 = 3'd7; mode6 = 1'b0; en6 = 1'b1; rdy6 = 1'b1;
        cycle("oor");
        chk("oor.y", {4'd0, y6}, 8'd0);
        chk("oor.ch", {5'd0, ch6}, 8'd7);
        chk("oor.err", {7'd0, err6}, 8'd1);

        // B: 14 scan captures wrap 0..5
        mode6 = 1'b1;
        for (int i = 0; i < 14; i++) begin
            rand_a();
            d6 = 24'($urandom);
            cycle("scan14");
            chk("scan14.ch", {5'd0, ch6}, 8'(i % 6));
            chk("scan14.last", {7'd0, last6}, {7'd0, (i % 6) == 5});
        end

        // B: backpressure holds channel 0, then continues at channel 1
        mode6 = 1'b0; en6 = 1'b0; rdy6 = 1'b1;
        cycle("bp_drain");
        mode6 = 1'b1; en6 = 1'b1; rdy6 = 1'b0;
        cycle("bp_first");
        for (int i = 0; i < 5; i++) begin
            d6 = 24'($urandom); sel6 = 3'($urandom);
            cycle("bp_hold");
            chk("bp_hold.ch", {5'd0, ch6}, 8'd0);
            chk("bp_hold.valid", {7'd0, v6}, 8'd1);
        end
        rdy6 = 1'b1;
        cycle("bp_resume");
        chk("bp_resume.ch", {5'd0, ch6}, 8'd1);

        // B: reset pulse mid-scan at ptr=3
        mode6 = 1'b0;
        cycle("rst_prep");
        mode6 = 1'b1; en6 = 1'b1; rdy6 = 1'b1;
        for (int i = 0; i < 3; i++) cycle("rst_scan");
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("rst_async");
        #1;
        rst_n = 1'b1;
        cycle("rst_after");
        chk("rst_after.ch", {5'd0, ch6}, 8'd0);
        chk("rst_after.valid", {7'd0, v6}, 8'd1);

        // B: mode 1 -> 0 -> 1 with capture on every edge
        mode6 = 1'b1; sel6 = 3'd2;
        cycle("m_scan");
        cycle("m_scan");
        mode6 = 1'b0; sel6 = 3'd4; d6 = 24'h0A_0000;
        cycle("m_manual");
        chk("m_manual.ch", {5'd0, ch6}, 8'd4);
        chk("m_manual.y", {4'd0, y6}, 8'hA);
        mode6 = 1'b1;
        cycle("m_rescan");
        chk("m_rescan.ch", {5'd0, ch6}, 8'd0);

        // Fully random traffic on both instances
        for (int i = 0; i < 400; i++) begin
            rand_a();
            rand_b();
            cycle("random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
